// File: rtl/aor3000_block_irq_ctrl_pkg.sv
// Shared constants for the PSX-style interrupt controller: source indices,
// register offsets, the CP0 IP line it drives, and the byte-lane helper.
package aor3000_block_irq_ctrl_pkg;

    typedef enum logic [3:0] {
        VBLANK   = 4'd0,
        GPU      = 4'd1,
        CDROM    = 4'd2,
        DMA      = 4'd3,
        TMR0     = 4'd4,
        TMR1     = 4'd5,
        TMR2     = 4'd6,
        PAD      = 4'd7,
        SIO      = 4'd8,
        SPU      = 4'd9,
        LIGHTPEN = 4'd10
    } irq_src_e;

    localparam logic [1:0] ISTAT_SEL  = 2'd0;
    localparam logic [1:0] IMASK_SEL  = 2'd1;
    localparam int         CP0_IP_IDX = 0;

    // Disabled byte lanes read back as all-ones so an AND with the result keeps them.
    function automatic logic [31:0] lane_fill(input logic [31:0] data, input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = be[b] ? data[8*b +: 8] : 8'hFF;
        return r;
    endfunction

endpackage

// File: rtl/aor3000_block_irq_ctrl_if.sv
// Single-word register bus between software and the interrupt controller.
interface aor3000_block_irq_ctrl_if;
    logic [1:0]  bus_addr;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byteenable;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_addr, bus_read, bus_write, bus_wdata, bus_byteenable,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_addr, bus_read, bus_write, bus_wdata, bus_byteenable,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/aor3000_block_irq_ctrl_edge_sync.sv
// Per-bit rising-edge detector for interrupt sources. With IRQ_CTRL_SYNC_EN
// defined, each bit first crosses a DEPTH-flop synchronizer.
module aor3000_irq_edge_sync #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] src,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;

`ifdef IRQ_CTRL_SYNC_EN
    logic [DEPTH-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[DEPTH-2:0], src};
    end

    assign sync = sync_q[DEPTH-1];
`else
    localparam int unused_depth = DEPTH;
    assign sync = src;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= '0;
        else        prev <= sync;
    end

    assign rise = sync & ~prev;

endmodule

// File: rtl/aor3000_block_irq_ctrl.sv
// PSX-style interrupt controller: latches source edges into I_STAT, masks with
// I_MASK, drives CP0 IP2. IRQ_CTRL_SYNC_EN adds input synchronizers.
module aor3000_block_irq_ctrl
    import aor3000_block_irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 11,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SRC-1:0]     irq_src,
    aor3000_block_irq_ctrl_if.slave bus,
    output logic [5:0]             interrupt_vector
);

    logic [NUM_SRC-1:0] stat, mask, rise, stat_next, mask_next;
    logic [31:0]        wmask, keep, rd_val, rdata_q;
    logic               irq_q, ack_q, wr_stat, wr_mask;
    logic               unused_hi;

    aor3000_irq_edge_sync #(
        .WIDTH (NUM_SRC),
        .DEPTH (SYNC_STAGES)
    ) u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .src   (irq_src),
        .rise  (rise)
    );

    assign wr_stat   = bus.bus_write && (bus.bus_addr == ISTAT_SEL);
    assign wr_mask   = bus.bus_write && (bus.bus_addr == IMASK_SEL);
    assign wmask     = lane_fill(bus.bus_wdata, bus.bus_byteenable);
    assign keep      = lane_fill(32'h0, bus.bus_byteenable);
    assign unused_hi = ^{wmask[31:NUM_SRC], keep[31:NUM_SRC], bus.bus_wdata[31:NUM_SRC]};

    // A rise is ORed in after the acknowledge mask, so it beats a same-cycle clear.
    always_comb begin
        stat_next = wr_stat ? ((stat & wmask[NUM_SRC-1:0]) | rise) : (stat | rise);
        mask_next = wr_mask ? ((mask & keep[NUM_SRC-1:0]) |
                               (bus.bus_wdata[NUM_SRC-1:0] & ~keep[NUM_SRC-1:0]))
                            : mask;
        case (bus.bus_addr)
            ISTAT_SEL: rd_val = 32'(stat);
            IMASK_SEL: rd_val = 32'(mask);
            default:   rd_val = '0;
        endcase
    end

    // The IRQ flop samples the current registers, so it trails stat/mask by one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat    <= '0;
            mask    <= '0;
            irq_q   <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            stat    <= stat_next;
            mask    <= mask_next;
            irq_q   <= |(stat & mask);
            ack_q   <= bus.bus_read | bus.bus_write;
            rdata_q <= bus.bus_read ? rd_val : '0;
        end
    end

    assign bus.bus_ack   = ack_q;
    assign bus.bus_rdata = rdata_q;

    always_comb begin
        interrupt_vector             = '0;
        interrupt_vector[CP0_IP_IDX] = irq_q;
    end

endmodule

// File: tb/tb_aor3000_block_irq_ctrl.sv
// Self-checking bench for aor3000_block_irq_ctrl against a cycle-level
// behavioural model of I_STAT/I_MASK built from source-edge history.
module tb_aor3000_block_irq_ctrl;

    localparam int NUM_SRC = 11;
    localparam int SYNC    = 2;
`ifdef IRQ_CTRL_SYNC_EN
    localparam int S = SYNC;
`else
    localparam int S = 0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [NUM_SRC-1:0] irq_src = '0;
    logic [5:0]         interrupt_vector;

    aor3000_block_irq_ctrl_if bus ();

    aor3000_block_irq_ctrl #(
        .NUM_SRC     (NUM_SRC),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .irq_src          (irq_src),
        .bus              (bus.slave),
        .interrupt_vector (interrupt_vector)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model state: registers as software sees them plus expected bus/IRQ outputs.
    logic [NUM_SRC-1:0] m_stat, m_mask;
    logic [NUM_SRC-1:0] hist [0:S+1];
    logic               m_irq, m_ack;
    logic [31:0]        m_rdata;

    task automatic model_reset();
        m_stat = '0; m_mask = '0; m_irq = 0; m_ack = 0; m_rdata = '0;
        for (int k = 0; k <= S + 1; k++) hist[k] = '0;
    endtask

    task automatic model_edge(input logic rd, input logic wr, input logic [1:0] a,
                              input logic [31:0] wd, input logic [3:0] be,
                              input logic [NUM_SRC-1:0] src);
        logic [NUM_SRC-1:0] rise, old_stat, old_mask;
        for (int k = S + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = src;
        rise     = hist[S] & ~hist[S+1];
        old_stat = m_stat;
        old_mask = m_mask;
        m_irq    = |(old_stat & old_mask);
        m_ack    = rd | wr;
        m_rdata  = '0;
        if (rd) begin
            if (a == 2'd0) m_rdata = 32'(old_stat);
            else if (a == 2'd1) m_rdata = 32'(old_mask);
        end
        if (wr) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (be[i/8]) begin
                    if (a == 2'd0 && !wd[i]) m_stat[i] = 1'b0;
                    if (a == 2'd1) m_mask[i] = wd[i];
                end
            end
        end
        m_stat = m_stat | rise;
    endtask

    // One clock: drive request and sources, advance, update model, sample point.
    task automatic cycle(input logic rd, input logic wr, input logic [1:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic [NUM_SRC-1:0] src);
        bus.bus_read = rd; bus.bus_write = wr; bus.bus_addr = a;
        bus.bus_wdata = wd; bus.bus_byteenable = be; irq_src = src;
        @(posedge clk);
        model_edge(rd, wr, a, wd, be, src);
        #1;
        bus.bus_read = 1'b0; bus.bus_write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 2'd0, 32'h0, 4'h0, irq_src);
    endtask

    task automatic test_reset();
        irq_src = 11'h7FF;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (interrupt_vector !== 6'h0) begin miscompares++; $display("FAIL reset_iv got=%h exp=0", interrupt_vector); end
        vectors++;
        if (bus.bus_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack got=%b exp=0", bus.bus_ack); end
        vectors++;
        if (bus.bus_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got=%h exp=0", bus.bus_rdata); end
        rst_n = 1'b1;
        idle(S + 3);
        cycle(1, 0, 2'd0, 32'h0, 4'h0, 11'h7FF);
        vectors++;
        if (bus.bus_ack !== 1'b1 || bus.bus_rdata !== 32'h7FF) begin
            miscompares++; $display("FAIL reset_edge_once ack=%b rdata=%h exp ack=1 rdata=7ff", bus.bus_ack, bus.bus_rdata);
        end
        cycle(0, 1, 2'd0, 32'h0, 4'hF, 11'h7FF);
        idle(S + 3);
        cycle(1, 0, 2'd0, 32'h0, 4'h0, 11'h7FF);
        vectors++;
        if (bus.bus_rdata !== 32'h0 || bus.bus_rdata !== m_rdata) begin
            miscompares++; $display("FAIL level_ignored got=%h exp=0", bus.bus_rdata);
        end
    endtask

    task automatic test_reset_abort();
        irq_src = '0;
        bus.bus_addr = 2'd1; bus.bus_read = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (bus.bus_ack !== 1'b0) begin miscompares++; $display("FAIL abort_ack got=%b exp=0", bus.bus_ack); end
        bus.bus_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        idle(1);
        vectors++;
        if (bus.bus_ack !== 1'b0 || bus.bus_rdata !== 32'h0) begin
            miscompares++; $display("FAIL abort_no_late_ack ack=%b rdata=%h exp 0/0", bus.bus_ack, bus.bus_rdata);
        end
    endtask

    task automatic test_latency();
        logic exp;
        cycle(0, 1, 2'd1, 32'h1, 4'hF, '0);
        cycle(0, 1, 2'd0, 32'h0, 4'hF, '0);
        idle(S + 3);
        for (int k = 0; k <= S + 4; k++) begin
            cycle(0, 0, 2'd0, 32'h0, 4'h0, (k == 0) ? 11'h001 : 11'h000);
            exp = (k >= S + 1);
            vectors++;
            if (interrupt_vector !== {5'b0, exp} || interrupt_vector[0] !== m_irq) begin
                miscompares++; $display("FAIL latency_k%0d got=%b exp=%b", k, interrupt_vector, {5'b0, exp});
            end
        end
        cycle(1, 0, 2'd0, 32'h0, 4'h0, '0);
        vectors++;
        if (bus.bus_rdata !== 32'h1) begin miscompares++; $display("FAIL latency_stat got=%h exp=1", bus.bus_rdata); end
    endtask

    task automatic test_ack_clear();
        cycle(0, 1, 2'd0, 32'h0, 4'hF, '0);
        cycle(0, 0, 2'd0, 32'h0, 4'h0, 11'h005);
        idle(S + 2);
        cycle(0, 1, 2'd1, 32'h4, 4'hF, '0);
        idle(2);
        cycle(0, 1, 2'd0, 32'hFFFF_FFFB, 4'hF, '0);
        vectors++;
        if (interrupt_vector[0] !== 1'b1) begin miscompares++; $display("FAIL ack_iv_hold got=%b exp=1", interrupt_vector[0]); end
        cycle(1, 0, 2'd0, 32'h0, 4'h0, '0);
        vectors++;
        if (interrupt_vector[0] !== 1'b0) begin miscompares++; $display("FAIL ack_iv_drop got=%b exp=0", interrupt_vector[0]); end
        vectors++;
        if (bus.bus_rdata !== 32'h1) begin miscompares++; $display("FAIL ack_stat got=%h exp=1", bus.bus_rdata); end
    endtask

    task automatic test_same_cycle();
        cycle(0, 1, 2'd0, 32'h0, 4'hF, '0);
        cycle(0, 0, 2'd0, 32'h0, 4'h0, 11'h008);
        idle(S + 2);
        cycle(0, 0, 2'd0, 32'h0, 4'h0, '0);
        // Time the source so its detected rise lands on the clearing write's edge.
        for (int j = 0; j <= S; j++)
            cycle(0, (j == S), 2'd0, 32'h0, 4'hF, 11'h008);
        cycle(1, 0, 2'd0, 32'h0, 4'h0, '0);
        vectors++;
        if (bus.bus_rdata !== 32'h8 || bus.bus_rdata !== m_rdata) begin
            miscompares++; $display("FAIL rise_beats_clear got=%h exp=8", bus.bus_rdata);
        end
    endtask

    task automatic test_byte_lanes();
        cycle(0, 1, 2'd1, 32'h0, 4'hF, '0);
        cycle(0, 1, 2'd1, 32'h0000_07FF, 4'b0010, '0);
        cycle(1, 0, 2'd1, 32'h0, 4'h0, '0);
        vectors++;
        if (bus.bus_rdata !== 32'h700) begin miscompares++; $display("FAIL mask_lane got=%h exp=700", bus.bus_rdata); end
        cycle(0, 1, 2'd0, 32'h0, 4'hF, '0);
        cycle(0, 0, 2'd0, 32'h0, 4'h0, 11'h7FF);
        idle(S + 2);
        cycle(0, 1, 2'd0, 32'h0, 4'b0001, '0);
        cycle(1, 0, 2'd0, 32'h0, 4'h0, '0);
        vectors++;
        if (bus.bus_rdata !== 32'h700) begin miscompares++; $display("FAIL stat_lane got=%h exp=700", bus.bus_rdata); end
    endtask

    task automatic test_back_to_back();
        cycle(1, 0, 2'd1, 32'h0, 4'h0, '0);
        vectors++;
        if (bus.bus_ack !== 1'b1 || bus.bus_rdata !== 32'h700) begin
            miscompares++; $display("FAIL b2b_rd_mask ack=%b rdata=%h exp 1/700", bus.bus_ack, bus.bus_rdata);
        end
        cycle(1, 0, 2'd2, 32'h0, 4'h0, '0);
        vectors++;
        if (bus.bus_ack !== 1'b1 || bus.bus_rdata !== 32'h0) begin
            miscompares++; $display("FAIL b2b_rd_rsvd ack=%b rdata=%h exp 1/0", bus.bus_ack, bus.bus_rdata);
        end
        cycle(0, 1, 2'd1, 32'h0FF, 4'hF, '0);
        vectors++;
        if (bus.bus_ack !== 1'b1) begin miscompares++; $display("FAIL b2b_wr_ack got=%b exp=1", bus.bus_ack); end
        idle(1);
        vectors++;
        if (bus.bus_ack !== 1'b0 || bus.bus_rdata !== 32'h0) begin
            miscompares++; $display("FAIL b2b_idle ack=%b rdata=%h exp 0/0", bus.bus_ack, bus.bus_rdata);
        end
        cycle(1, 1, 2'd1, 32'h3, 4'hF, '0);
        vectors++;
        if (bus.bus_ack !== 1'b1 || bus.bus_rdata !== 32'h0FF) begin
            miscompares++; $display("FAIL rdwr_same ack=%b rdata=%h exp 1/0ff", bus.bus_ack, bus.bus_rdata);
        end
        cycle(1, 0, 2'd1, 32'h0, 4'h0, '0);
        vectors++;
        if (bus.bus_rdata !== 32'h3) begin miscompares++; $display("FAIL rdwr_applied got=%h exp=3", bus.bus_rdata); end
    endtask

    task automatic test_random();
        logic [NUM_SRC-1:0] src;
        logic rd, wr;
        src = '0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3) == 0) src = NUM_SRC'($urandom);
            rd = ($urandom_range(2) == 0);
            wr = ($urandom_range(3) == 0);
            cycle(rd, wr, 2'($urandom), ($urandom_range(1) == 0) ? 32'hFFFF_FFFF ^ (32'h1 << $urandom_range(10)) : $urandom,
                  4'($urandom), src);
            vectors++;
            if (bus.bus_ack !== m_ack) begin miscompares++; $display("FAIL rnd_ack n=%0d got=%b exp=%b", n, bus.bus_ack, m_ack); end
            vectors++;
            if (bus.bus_rdata !== m_rdata) begin miscompares++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, bus.bus_rdata, m_rdata); end
            vectors++;
            if (interrupt_vector !== {5'b0, m_irq}) begin
                miscompares++; $display("FAIL rnd_iv n=%0d got=%b exp=%b", n, interrupt_vector, {5'b0, m_irq});
            end
        end
    endtask

    initial begin
        bus.bus_read = 1'b0; bus.bus_write = 1'b0; bus.bus_addr = 2'd0;
        bus.bus_wdata = 32'h0; bus.bus_byteenable = 4'h0;
        model_reset();
        #1;
        test_reset();
        test_reset_abort();
        test_latency();
        test_ack_clear();
        test_same_cycle();
        test_byte_lanes();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
